// File: rtl/amul_pkg.sv
// amul_pkg
// Shared definitions for the pipelined approximate multiplier.
//   PW              default product width (2 * default operand width)
//   COMP_BIAS       compensation bias for the default truncation column
//   amul_comp_bias  bias for an arbitrary truncation column / approximated row count
//   amul_ref_approx bit-accurate behavioural model of one multiplication
//                   (operands up to 32 bits, result returned at 64 bits)
package amul_pkg;

  localparam int W_DEF         = 8;
  localparam int PW            = 2 * W_DEF;
  localparam int TRUNC_COL_DEF = 7;

  localparam logic [63:0] COMP_BIAS = 64'(1) << (TRUNC_COL_DEF - 1);

  // The bias only makes sense when something is actually truncated:
  // no approximated rows, or a truncation column of zero, means no bias.
  function automatic logic [63:0] amul_comp_bias(input int trunc_col, input int l);
    logic [63:0] bias;
    bias = '0;
    if (trunc_col > 0 && l > 0) begin
      bias = 64'(1) << (trunc_col - 1);
    end
    return bias;
  endfunction

  // Rows at or above l are summed exactly. Rows below l lose every
  // partial-product bit whose weight is below 2^trunc_col, unless the
  // transaction asked for an exact product.
  function automatic logic [63:0] amul_ref_approx(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        exact,
    input int          l,
    input int          trunc_col,
    input logic        comp
  );
    logic [63:0] hi;
    logic [63:0] lo;
    logic [63:0] pp;
    hi = '0;
    lo = '0;
    for (int i = 0; i < 32; i++) begin
      pp = x[i] ? (64'(y) << i) : 64'(0);
      if (i >= l) begin
        hi = hi + pp;
      end else begin
        if (!exact) begin
          pp = pp & ~((64'(1) << trunc_col) - 64'(1));
        end
        lo = lo + pp;
      end
    end
    if (!exact && comp) begin
      lo = lo + amul_comp_bias(trunc_col, l);
    end
    return hi + lo;
  endfunction

endpackage

// File: rtl/amul_lo_rows.sv
// amul_lo_rows
// Combinational generator for the low L multiplier rows (x bits 0..L-1).
// Produces both the exact sum of those rows and the truncated sum in which
// every partial-product bit of weight below 2^TRUNC_COL is dropped.
// Ports:
//   i_x          multiplier operand (only bits 0..L-1 are used)
//   i_y          multiplicand operand
//   o_lo_exact   exact sum of the low rows, 2W bits
//   o_lo_approx  truncated sum of the low rows, 2W bits
module amul_lo_rows
  import amul_pkg::*;
#(
  parameter int W         = 8,
  parameter int L         = 6,
  parameter int TRUNC_COL = 7
) (
  input  logic [W-1:0]   i_x,
  input  logic [W-1:0]   i_y,
  output logic [2*W-1:0] o_lo_exact,
  output logic [2*W-1:0] o_lo_approx
);

  localparam int ZW = 2 * W;

  // Columns at or above TRUNC_COL survive truncation.
  localparam logic [ZW-1:0] KEEP_MASK = ~((ZW'(1) << TRUNC_COL) - ZW'(1));

  logic [ZW-1:0] w_pp;

  // Masking each shifted row before accumulation is the same as dropping
  // the individual partial-product bits below the truncation column, so
  // the approximate sum never sees carries out of the dropped region.
  always_comb begin
    o_lo_exact  = '0;
    o_lo_approx = '0;
    w_pp        = '0;
    for (int i = 0; i < L; i++) begin
      w_pp        = i_x[i] ? (ZW'(i_y) << i) : '0;
      o_lo_exact  = o_lo_exact + w_pp;
      o_lo_approx = o_lo_approx + (w_pp & KEEP_MASK);
    end
  end

endmodule

// File: rtl/amul_pipe_approx.sv
// amul_pipe_approx
// Two-stage pipelined unsigned approximate multiplier with valid/ready
// handshakes on both sides and a saturating count of approximate operations.
// Optional build macro: AMUL_COMP_EN adds a compensation bias of
// 2^(TRUNC_COL-1) to approximate results (only when TRUNC_COL > 0 and L > 0).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake
//   in_x, in_y            multiplier / multiplicand
//   in_exact              1 = exact product for this transaction
//   out_valid / out_ready result handshake
//   out_z                 2W-bit product
//   out_exact             in_exact echoed alongside its result
//   approx_cnt            saturating count of accepted approximate transactions
module amul_pipe_approx
  import amul_pkg::*;
#(
  parameter int W         = 8,
  parameter int L         = 6,
  parameter int TRUNC_COL = 7,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_z,
  output logic             out_exact,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int ZW = 2 * W;

  // Keeps only x bits L..W-1, so y * (x & mask) equals (y * x[W-1:L]) << L.
  localparam logic [W-1:0] X_HI_MASK = ~((W'(1) << L) - W'(1));

`ifdef AMUL_COMP_EN
  localparam logic [ZW-1:0] BIAS = ZW'(amul_comp_bias(TRUNC_COL, L));
`else
  localparam logic [ZW-1:0] BIAS = '0;
`endif

  logic [ZW-1:0]    w_hi;
  logic [ZW-1:0]    w_lo_exact;
  logic [ZW-1:0]    w_lo_approx;
  logic [ZW-1:0]    w_lo_sel;
  logic             w_s2_adv;
  logic             w_in_fire;

  logic             r_s1_valid;
  logic [ZW-1:0]    r_s1_hi;
  logic [ZW-1:0]    r_s1_lo;
  logic             r_s1_exact;
  logic             r_s2_valid;
  logic [ZW-1:0]    r_s2_z;
  logic             r_s2_exact;
  logic [CNT_W-1:0] r_cnt;

  amul_lo_rows #(
    .W         (W),
    .L         (L),
    .TRUNC_COL (TRUNC_COL)
  ) u_lo_rows (
    .i_x         (in_x),
    .i_y         (in_y),
    .o_lo_exact  (w_lo_exact),
    .o_lo_approx (w_lo_approx)
  );

  // The upper rows are always exact. The low rows pick the exact or the
  // truncated sum per transaction; any compensation bias only ever rides
  // on the truncated sum, so exact results are untouched by the build option.
  // The stall logic looks only at stage occupancy and out_ready, never at
  // in_valid. Stage 1 may load whenever it is empty or its content moves on
  // to stage 2 this cycle. During reset the block reports ready because
  // everything in flight is about to be discarded anyway.
  always_comb begin
    w_hi      = ZW'(in_y) * ZW'(in_x & X_HI_MASK);
    w_lo_sel  = in_exact ? w_lo_exact : (w_lo_approx + BIAS);
    w_s2_adv  = !r_s2_valid || out_ready;
    in_ready  = rst || !r_s1_valid || w_s2_adv;
    w_in_fire = in_valid && in_ready;
  end

  // Pipeline registers. Data registers only load alongside a valid token so
  // a stalled result keeps its value; the valid flags are updated so that a
  // simultaneous drain and fill leaves occupancy unchanged. The approximate
  // counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_hi    <= '0;
      r_s1_lo    <= '0;
      r_s1_exact <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_z     <= '0;
      r_s2_exact <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_z     <= r_s1_hi + r_s1_lo;
          r_s2_exact <= r_s1_exact;
        end
        r_s1_valid <= 1'b0;
      end
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_hi    <= w_hi;
        r_s1_lo    <= w_lo_sel;
        r_s1_exact <= in_exact;
        if (!in_exact && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_z      = r_s2_z;
  assign out_exact  = r_s2_exact;
  assign approx_cnt = r_cnt;

endmodule
